// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator.
//   imm_mode_e     : encoding of the 2-bit in_mode field
//   SHORT_SIGN_BIT : sign bit position of the short (3-bit) immediate form
//   max_pfx()      : number of PREFIX fields that fit ahead of a final
//                    field before upper accumulator bits start to be lost
package imm_pkg;

    typedef enum logic [1:0] {
        SHORT_S = 2'd0,
        LONG_S  = 2'd1,
        LONG_Z  = 2'd2,
        PREFIX  = 2'd3
    } imm_mode_e;

    localparam int SHORT_SIGN_BIT = 2;

    // ceil((data_w - field_w) / field_w), never negative
    function automatic int max_pfx(input int data_w, input int field_w);
        if (data_w <= field_w) begin
            return 0;
        end
        return (data_w - field_w + field_w - 1) / field_w;
    endfunction

endpackage

// File: rtl/imm_field_ext.sv
// Combinational extension of one instruction immediate field to DATA_W bits.
// Ports:
//   field : raw instruction immediate bits (FIELD_W)
//   mode  : extension mode (imm_mode_e encoding); PREFIX extends like LONG_Z
//   ext   : extended immediate (DATA_W)
module imm_field_ext
    import imm_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int FIELD_W = 6
) (
    input  logic [FIELD_W-1:0] field,
    input  logic [1:0]         mode,
    output logic [DATA_W-1:0]  ext
);

    imm_mode_e mode_e;
    assign mode_e = imm_mode_e'(mode);

    always_comb begin
        ext = '0;
        case (mode_e)
            SHORT_S: begin
                for (int i = 0; i <= SHORT_SIGN_BIT; i++) begin
                    ext[i] = field[i];
                end
                for (int i = SHORT_SIGN_BIT + 1; i < DATA_W; i++) begin
                    ext[i] = field[SHORT_SIGN_BIT];
                end
            end
            LONG_S: begin
                for (int i = 0; i < FIELD_W; i++) begin
                    ext[i] = field[i];
                end
                for (int i = FIELD_W; i < DATA_W; i++) begin
                    ext[i] = field[FIELD_W-1];
                end
            end
            default: begin
                // LONG_Z, and PREFIX when it reaches the extender
                ext[FIELD_W-1:0] = field;
            end
        endcase
    end

endmodule

// File: rtl/imm_extend_unit.sv
// Pipelined immediate generator between instruction decode and the ALU
// operand mux. One registered output stage with valid/ready on both sides.
// Optional feature macro: IMM_PREFIX_EN enables PREFIX accumulation
// (without it, mode 3 extends like LONG_Z and pfx_ovf is tied low).
// Ports:
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : field handshake from decode
//   in_field, in_mode    : raw immediate bits and extension mode
//   flush                : drop pending prefix state and any held result
//   out_valid / out_ready: result handshake to the consumer
//   imm_out              : extended immediate
//   pfx_ovf              : sticky, set when more prefixes arrive than fit
module imm_extend_unit
    import imm_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int FIELD_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FIELD_W-1:0] in_field,
    input  logic [1:0]         in_mode,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  imm_out,
    output logic               pfx_ovf
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] ext_val;
    logic [DATA_W-1:0] result;
    logic              take_result;
    logic              in_fire, out_fire;

    imm_field_ext #(
        .DATA_W (DATA_W),
        .FIELD_W(FIELD_W)
    ) u_field_ext (
        .field(in_field),
        .mode (in_mode),
        .ext  (ext_val)
    );

    assign in_ready  = !out_valid_q || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign imm_out   = imm_q;

`ifdef IMM_PREFIX_EN
    localparam int MAX_PFX = max_pfx(DATA_W, FIELD_W);
    localparam int CNT_W   = $clog2(MAX_PFX + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PFX);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_PFX + 1);

    logic [DATA_W-1:0] pfx_acc_q, pfx_acc_d;
    logic [CNT_W-1:0]  pfx_cnt_q, pfx_cnt_d;
    logic              pfx_pending_q, pfx_pending_d;
    logic              pfx_ovf_q, pfx_ovf_d;
    logic [DATA_W-1:0] pfx_join;
    logic              is_pfx;

    // (acc << FIELD_W) | field, keeping only the low DATA_W bits
    assign pfx_join    = DATA_W'({pfx_acc_q, in_field});
    assign is_pfx      = (imm_mode_e'(in_mode) == PREFIX);
    assign take_result = in_fire && !is_pfx;
    // A pending prefix overrides the mode's own extension
    assign result      = pfx_pending_q ? pfx_join : ext_val;
    assign pfx_ovf     = pfx_ovf_q;

    always_comb begin
        pfx_acc_d     = pfx_acc_q;
        pfx_cnt_d     = pfx_cnt_q;
        pfx_pending_d = pfx_pending_q;
        pfx_ovf_d     = pfx_ovf_q;
        if (flush) begin
            pfx_acc_d     = '0;
            pfx_cnt_d     = '0;
            pfx_pending_d = 1'b0;
            pfx_ovf_d     = 1'b0;
        end else if (in_fire) begin
            if (is_pfx) begin
                pfx_acc_d     = pfx_join;
                pfx_pending_d = 1'b1;
                if (pfx_cnt_q != CNT_SAT) begin
                    pfx_cnt_d = pfx_cnt_q + 1'b1;
                end
                // Already holding as many prefixes as fit: bits are lost
                if (pfx_cnt_q >= CNT_MAX) begin
                    pfx_ovf_d = 1'b1;
                end
            end else begin
                pfx_acc_d     = '0;
                pfx_cnt_d     = '0;
                pfx_pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pfx_acc_q     <= '0;
            pfx_cnt_q     <= '0;
            pfx_pending_q <= 1'b0;
            pfx_ovf_q     <= 1'b0;
        end else begin
            pfx_acc_q     <= pfx_acc_d;
            pfx_cnt_q     <= pfx_cnt_d;
            pfx_pending_q <= pfx_pending_d;
            pfx_ovf_q     <= pfx_ovf_d;
        end
    end
`else
    assign take_result = in_fire;
    assign result      = ext_val;
    assign pfx_ovf     = 1'b0;
`endif

    // Output stage: a new result may replace the old one in the same cycle
    // it is consumed; flush drops both the held result and any new one.
    always_comb begin
        out_valid_d = out_valid_q;
        imm_d       = imm_q;
        if (out_fire) begin
            out_valid_d = 1'b0;
        end
        if (take_result && !flush) begin
            out_valid_d = 1'b1;
            imm_d       = result;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            imm_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            imm_q       <= imm_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_unit.sv
module tb_imm_extend_unit;

    localparam int DW  = 8;
    localparam int FW  = 6;
    localparam int MOD = 1 << DW;
    localparam int FMOD = 1 << FW;
`ifdef IMM_PREFIX_EN
    localparam bit PFX_EN = 1'b1;
`else
    localparam bit PFX_EN = 1'b0;
`endif
    localparam int MAXP = (DW > FW) ? (DW - FW + FW - 1) / FW : 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_field;
    logic [1:0]    in_mode;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] imm_out;
    logic          pfx_ovf;

    imm_extend_unit #(
        .DATA_W (DW),
        .FIELD_W(FW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_field (in_field),
        .in_mode  (in_mode),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .imm_out  (imm_out),
        .pfx_ovf  (pfx_ovf)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state, kept as plain integers
    int m_valid, m_imm, m_acc, m_cnt, m_pend, m_ovf;

    typedef struct {
        int mode;
        int field;
        int exp;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ext_ref(input int mode, input int f);
        int v;
        case (mode)
            0: begin v = f % 8;    if (v >= 4)        v -= 8;    end
            1: begin v = f;        if (v >= FMOD / 2) v -= FMOD; end
            default: v = f;
        endcase
        return (v + MOD) % MOD;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_imm = 0; m_acc = 0; m_cnt = 0; m_pend = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit v, input int mode, input int f,
                              input bit fl, input bit ordy);
        bit rdy;
        rdy = !m_valid || ordy;
        if (fl) begin
            m_valid = 0; m_acc = 0; m_cnt = 0; m_pend = 0; m_ovf = 0;
            return;
        end
        if (m_valid && ordy) m_valid = 0;
        if (v && rdy) begin
            if (PFX_EN && mode == 3) begin
                if (m_cnt >= MAXP) m_ovf = 1;
                m_acc  = (m_acc * FMOD + f) % MOD;
                m_cnt  = (m_cnt + 1 > MAXP + 1) ? MAXP + 1 : m_cnt + 1;
                m_pend = 1;
            end else begin
                if (m_pend) begin
                    m_imm = (m_acc * FMOD + f) % MOD;
                    m_acc = 0; m_cnt = 0; m_pend = 0;
                end else begin
                    m_imm = ext_ref(mode, f);
                end
                m_valid = 1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " out_valid"}, int'(out_valid), m_valid);
        chk({tag, " imm_out"},   int'(imm_out),   m_imm);
        chk({tag, " pfx_ovf"},   int'(pfx_ovf),   m_ovf);
    endtask

    // Called just after a falling edge; ends just after the next one.
    task automatic cycle(input bit v, input int mode, input int f,
                         input bit fl, input bit ordy, input string tag);
        in_valid  = v;
        in_mode   = 2'(mode);
        in_field  = FW'(f);
        flush     = fl;
        out_ready = ordy;
        #1;
        chk({tag, " in_ready"}, int'(in_ready), (!m_valid || ordy) ? 1 : 0);
        model_step(v, mode, f, fl, ordy);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 6'b000101, 8'hFD};
        tbl[1] = '{0, 6'b111011, 8'h03};
        tbl[2] = '{1, 6'b100001, 8'hE1};
        tbl[3] = '{2, 6'b100001, 8'h21};
        tbl[4] = '{0, 6'b000111, 8'hFF};
        tbl[5] = '{0, 6'b111100, 8'hFC};
        tbl[6] = '{1, 6'b011111, 8'h1F};
        tbl[7] = '{1, 6'b100000, 8'hE0};
        tbl[8] = '{2, 6'b111111, 8'h3F};
        tbl[9] = '{1, 6'b111111, 8'hFF};

        rst_n = 1'b1; in_valid = 1'b0; in_mode = 2'd0; in_field = '0;
        flush = 1'b0; out_ready = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset imm_out",   int'(imm_out),   0);
        chk("reset pfx_ovf",   int'(pfx_ovf),   0);
        chk("reset in_ready",  int'(in_ready),  1);
        rst_n = 1'b1;

        // Table vectors, issued back to back with out_ready high
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, tbl[i].mode, tbl[i].field, 1'b0, 1'b1, "tbl");
            chk("tbl value", int'(imm_out), tbl[i].exp);
            chk("tbl b2b valid", int'(out_valid), 1);
        end
        cycle(1'b0, 0, 0, 1'b0, 1'b1, "drain");

        // Single prefix then LONG_S
        cycle(1'b1, 3, 6'h03, 1'b0, 1'b1, "pfx1a");
        chk("pfx1 no output", int'(out_valid), PFX_EN ? 0 : 1);
        cycle(1'b1, 1, 6'h05, 1'b0, 1'b1, "pfx1b");
        chk("pfx1 result", int'(imm_out), PFX_EN ? 8'hC5 : 8'h05);
        cycle(1'b0, 0, 0, 1'b0, 1'b1, "drain");

        // Two prefixes overflow, then flush clears the sticky flag
        cycle(1'b1, 3, 6'h01, 1'b0, 1'b1, "pfx2a");
        cycle(1'b1, 3, 6'h02, 1'b0, 1'b1, "pfx2b");
        cycle(1'b1, 2, 6'h07, 1'b0, 1'b1, "pfx2c");
        chk("pfx2 result", int'(imm_out), PFX_EN ? 8'h87 : 8'h07);
        chk("pfx2 ovf", int'(pfx_ovf), PFX_EN ? 1 : 0);
        cycle(1'b0, 0, 0, 1'b1, 1'b1, "flush");
        chk("flush ovf", int'(pfx_ovf), 0);

        // Flush wins over a same-cycle accept
        cycle(1'b1, 2, 6'h09, 1'b1, 1'b1, "flush_drop");
        chk("flush drop valid", int'(out_valid), 0);

        // Backpressure: result held, input stalled
        cycle(1'b1, 2, 6'h11, 1'b0, 1'b1, "bp0");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 2, 6'h22, 1'b0, 1'b0, "bp_hold");
            chk("bp stable imm", int'(imm_out), 8'h11);
            chk("bp in_ready", int'(in_ready), 0);
        end
        cycle(1'b1, 2, 6'h22, 1'b0, 1'b1, "bp_rel");
        chk("bp next value", int'(imm_out), 8'h22);
        cycle(1'b0, 0, 0, 1'b0, 1'b1, "drain");

        // Asynchronous reset in the middle of a prefix sequence
        cycle(1'b1, 2, 6'h2A, 1'b0, 1'b0, "rst_a");
        cycle(1'b0, 0, 0, 1'b0, 1'b1, "rst_b");
        cycle(1'b1, 3, 6'h15, 1'b0, 1'b1, "rst_c");
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", int'(out_valid), 0);
        chk("async rst imm_out",   int'(imm_out),   0);
        chk("async rst pfx_ovf",   int'(pfx_ovf),   0);
        chk("async rst in_ready",  int'(in_ready),  1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 2, 6'h05, 1'b0, 1'b1, "post_rst");
        chk("post rst value", int'(imm_out), 8'h05);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, FMOD - 1)),
                  ($urandom % 20) == 0, ($urandom % 4) != 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_extend_unit.md
# imm_extend_unit

Parametrised, pipelined immediate generator for the 8-bit processor decode path. It replaces the fixed two-format sign extender with:
- selectable extension modes;
- a prefix mechanism that builds immediates wider than one instruction field;
- valid/ready handshakes on both sides and one registered output stage.

It sits between instruction decode and the ALU operand mux.

## Interface
Parameters:
- DATA_W, 8, width of produced immediate; DATA_W >= FIELD_W
- FIELD_W, 6, width of instruction immediate field; FIELD_W >= 3

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decode presents a field
- in_ready  out  1  unit accepts field this cycle
- in_field  in  FIELD_W  raw instruction immediate bits
- in_mode  in  2  0 SHORT_S, 1 LONG_S, 2 LONG_Z, 3 PREFIX
- flush  in  1  discard pending prefix and output (pipeline flush)
- out_valid  out  1  imm_out holds a result
- out_ready  in  1  consumer takes result
- imm_out  out  DATA_W  extended immediate
- pfx_ovf  out  1  sticky: more prefixes than fit in DATA_W

## Operation
- Accept (in_fire) when in_valid && in_ready. Output handoff (out_fire) when out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is a single-stage pipeline with full throughput.
- Extension modes, when no prefix is pending:
  - SHORT_S: sign-extend in_field[2:0]; bit 2 is the sign.
  - LONG_S: sign-extend in_field[FIELD_W-1:0].
  - LONG_Z: zero-extend in_field[FIELD_W-1:0].
- PREFIX on in_fire:
  - pfx_acc <= (pfx_acc << FIELD_W) | in_field, truncated to DATA_W.
  - pfx_cnt increments, saturating at MAX_PFX+1.
  - pfx_pending <= 1.
  - No output is produced; out_valid is unaffected except by out_fire.
- Non-PREFIX in_fire with pfx_pending:
  - imm = ((pfx_acc << FIELD_W) | in_field), truncated to DATA_W. in_mode extension is ignored.
  - pfx_acc, pfx_cnt and pfx_pending are cleared.
- MAX_PFX = ceil((DATA_W-FIELD_W)/FIELD_W); minimum 0. A PREFIX accepted when pfx_cnt == MAX_PFX sets pfx_ovf. Accumulation still proceeds, and upper bits are lost.
- pfx_ovf is cleared only by flush or reset.
- flush:
  - Clears out_valid, pfx_acc, pfx_cnt, pfx_pending and pfx_ovf next edge.
  - An in_fire in the same cycle is dropped; flush wins.
  - A same-cycle out_fire still counts as consumed.
- imm_out holds its value while out_valid && !out_ready.

## Timing
- Latency: in_fire at edge N, so imm_out/out_valid are valid after edge N+1 (one cycle).
- Back-to-back non-PREFIX fields with out_ready = 1: one result per cycle.
- Simultaneous out_fire and in_fire (non-PREFIX): new result replaces old at the same edge; out_valid stays 1.
- PREFIX in_fire with out_fire and no new result: out_valid falls to 0.
- Reset (asynchronous assert, any cycle, including mid-prefix):
  - out_valid = 0, imm_out = 0, pfx_ovf = 0;
  - pfx_acc = 0, pfx_cnt = 0, pfx_pending = 0;
  - in_ready = 1 after reset.

## Configuration
- IMM_PREFIX_EN defined: PREFIX mode and the accumulator behave as above.
- IMM_PREFIX_EN undefined:
  - no accumulator registers are built;
  - mode 3 behaves as LONG_Z;
  - pfx_ovf is tied to 0.

## Structure
- Package imm_pkg holds:
  - the mode encoding typedef (SHORT_S/LONG_S/LONG_Z/PREFIX);
  - the SHORT_SIGN_BIT = 2 constant;
  - a function computing MAX_PFX from DATA_W/FIELD_W.
- One combinational sub-module, imm_field_ext (field + mode -> DATA_W extension). The top holds the handshake, output register and prefix accumulator.

## Test plan
All with DATA_W=8, FIELD_W=6, out_ready=1 unless stated.
- SHORT_S field 6'b000101 -> imm_out 8'hFD one cycle later. SHORT_S 6'b111011 -> 8'h03.
- LONG_S 6'b100001 -> 8'hE1. LONG_Z 6'b100001 -> 8'h21. Issue both back-to-back -> two consecutive out_valid cycles.
- PREFIX 6'h03, then LONG_S 6'h05 -> single result 8'hC5, no output for the prefix cycle. Repeat the prefix sequence with IMM_PREFIX_EN undefined -> mode 3 field 6'h03 gives 8'h03.
- Two PREFIX fields (6'h01, 6'h02), then LONG_Z 6'h07 -> pfx_ovf=1, imm_out 8'h87. Then flush -> pfx_ovf=0.
- Hold out_ready=0 with a result pending -> in_ready=0, imm_out stable over 5 cycles. Release -> next queued field appears the cycle after.
- Assert rst_n low after one PREFIX -> all outputs 0 immediately. After release, LONG_Z 6'h05 -> 8'h05 (no stale prefix).
